data_stack_mem_seq: RTL and testbench
=====================================

// Module: data_stack_mem_seq
// PURPOSE
//  Byte-addressable data memory with an integrated hardware stack, successor to the fixed 32-bit data/stack memory.
//  Serves LW/SW/PUSH/POP/CALL/RET from the pipeline through a valid/ready handshake.
//  Storage is one byte-wide array accessed one byte per cycle. Word width, depth, stack bounds and PC increment are parametrised.
//  Adds SP bounds checking with overflow/underflow faults and misalignment detection.
// PARAMETERS
//  DATA_W      32    word width in bits; multiple of 8; NB = DATA_W/8 bytes per word
//  ADDR_W      10    byte-address width; array holds 2**ADDR_W bytes
//  STACK_BASE  2**ADDR_W  SP reset value (empty stack); first push writes STACK_BASE-NB
//  STACK_LIMIT 768   lowest legal SP; stack must not grow below it
//  PC_INC      1     amount added to pc before CALL pushes it
//  ALIGN_CHK   1     1: LW/SW with addr % NB != 0 faults; 0: byte addresses wrap mod 2**ADDR_W
// PORTS
//  clk         in   1         clock, all state on rising edge
//  rst_n       in   1         asynchronous active-low reset
//  op_valid    in   1         request valid
//  op_ready    out  1         block idle, can accept
//  op          in   3         0 NOP,1 LW,2 SW,3 PUSH,4 POP,5 CALL,6 RET,7 NOP
//  addr        in   ADDR_W    byte address for LW/SW
//  wdata       in   DATA_W    store/push data
//  pc          in   DATA_W    current PC for CALL
//  rd_valid    out  1         1-cycle pulse, rd_data valid (LW, POP)
//  rd_data     out  DATA_W    load/pop result, held until next rd_valid
//  ret_valid   out  1         1-cycle pulse, ret_pc valid (RET)
//  ret_pc      out  DATA_W    popped return address, held until next ret_valid
//  sp          out  ADDR_W+1  current stack pointer
//  fault       out  1         1-cycle pulse, request rejected
//  fault_code  out  2         01 misaligned, 10 overflow, 11 underflow; held until next accept
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - state IDLE, sp=STACK_BASE, op_ready=1.
//   - rd_valid=ret_valid=fault=0; rd_data=ret_pc=0; fault_code=00.
//   - Array contents not reset.
//   - Reset mid-transfer aborts it: bytes already written stay written, no response is issued.
//  Handshake
//   - Accept when op_valid&&op_ready (edge E0); op/addr/wdata/pc captured at E0.
//   - op_ready=0 whenever not IDLE; op_valid while busy is ignored.
//   - NOP accepted with no effect and no response.
//  FSM IDLE -> XFER -> IDLE
//   - XFER moves byte i (i=0..NB-1) on edge E(i+1), little-endian: byte i = data[8i+7:8i] at base+i.
//   - After edge E(NB) state=IDLE, op_ready=1, and rd_valid or ret_valid pulses that cycle.
//   - Latency: NB cycles accept-to-response; next accept possible in the response cycle.
//  Base address / SP (SP updated at E0)
//   - LW/SW: base=addr.
//   - PUSH/CALL: sp=sp-NB, base=new sp; CALL data = pc+PC_INC (mod 2**DATA_W).
//   - POP/RET: base=old sp, sp=sp+NB.
//   - SW/PUSH/CALL produce no data response.
//  Faults (checked at E0)
//   - On fault: no array access, sp unchanged, no XFER.
//   - fault pulses in the cycle after E0 with fault_code set; op_ready stays 1.
//   - PUSH/CALL with sp-NB < STACK_LIMIT -> overflow (10).
//   - POP/RET with sp+NB > STACK_BASE -> underflow (11).
//   - ALIGN_CHK=1 and addr[log2(NB)-1:0]!=0 on LW/SW -> misaligned (01).
//  Boundaries
//   - ALIGN_CHK=0: base+i wraps mod 2**ADDR_W.
//   - sp==STACK_LIMIT blocks a push; sp==STACK_BASE blocks a pop.
//   - Stack and data share one array; SW into the stack region is legal and unchecked.
// TESTING
//  1 Reset: rst_n=0 mid-XFER -> sp=1024, op_ready=1, no rd_valid, all outputs 0.
//  2 SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> rd_valid 4 cycles after LW accept; rd_data=0xDEADBEEF; byte[0x10]=0xEF.
//  3 PUSH 0x11223344, PUSH 0x55667788; POP, POP -> 0x55667788 then 0x11223344; sp 1024->1016->1024.
//  4 CALL pc=0x40 then RET -> ret_valid with ret_pc=0x41; sp back to 1024.
//  5 POP at sp=1024 -> fault=1, code 11, sp=1024; 64 pushes to sp=768, 65th -> code 10, sp=768.
//  6 LW addr=0x13 with ALIGN_CHK=1 -> fault code 01, no rd_valid; ALIGN_CHK=0, SW addr=0x3FE -> bytes at 0x3FE,0x3FF,0x000,0x001.

Source files
------------

// File: rtl/data_stack_mem_seq.sv
// Byte-wide data memory with an integrated downward-growing hardware stack.
// Serves LW/SW/PUSH/POP/CALL/RET one byte per cycle behind a valid/ready handshake.
module data_stack_mem_seq #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int STACK_BASE  = 2**ADDR_W,
    parameter int STACK_LIMIT = 768,
    parameter int PC_INC      = 1,
    parameter int ALIGN_CHK   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] pc,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              ret_valid,
    output logic [DATA_W-1:0] ret_pc,
    output logic [ADDR_W:0]   sp,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int NB    = DATA_W / 8;
    localparam int SP_W  = ADDR_W + 1;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    localparam logic [2:0] OP_LW   = 3'd1;
    localparam logic [2:0] OP_SW   = 3'd2;
    localparam logic [2:0] OP_PUSH = 3'd3;
    localparam logic [2:0] OP_POP  = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_MIS  = 2'b01;
    localparam logic [1:0] FC_OVF  = 2'b10;
    localparam logic [1:0] FC_UNF  = 2'b11;

    // Bounds are compared one bit wider than sp so sp+NB never overflows.
    localparam logic [SP_W:0]       LIM_X      = (SP_W+1)'(STACK_LIMIT + NB);
    localparam logic [SP_W:0]       BASE_X     = (SP_W+1)'(STACK_BASE);
    localparam logic [SP_W:0]       NB_X       = (SP_W+1)'(NB);
    localparam logic [SP_W-1:0]     NB_SP      = SP_W'(NB);
    localparam logic [ADDR_W-1:0]   ALIGN_MASK = ADDR_W'(NB - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(NB - 1);
    localparam logic [DATA_W-1:0]   PC_STEP    = DATA_W'(PC_INC);

    logic [7:0]        mem [2**ADDR_W];

    logic [0:0]        state_r;
    logic [SP_W-1:0]   sp_r;
    logic [2:0]        op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              accept_s;
    logic              start_s;
    logic [1:0]        fcode_s;
    logic [ADDR_W-1:0] base_s;
    logic [SP_W-1:0]   sp_next_s;
    logic [DATA_W-1:0] data_s;
    logic [SP_W:0]     sp_x_s;
    logic              wr_s;
    logic [DATA_W-1:0] shift_s;

    assign op_ready = (state_r == S_IDLE);
    assign sp       = sp_r;
    assign accept_s = op_valid && op_ready;
    assign sp_x_s   = {1'b0, sp_r};
    assign wr_s     = (op_r == OP_SW) || (op_r == OP_PUSH) || (op_r == OP_CALL);
    // Bytes leave from the bottom and arrive at the top, so NB shifts rebuild a little-endian word.
    assign shift_s  = (data_r >> 8) | (DATA_W'(mem[addr_r]) << (DATA_W - 8));

    // Request decode: fault check, base address, next SP and write data.
    always_comb begin
        start_s   = 1'b0;
        fcode_s   = FC_NONE;
        base_s    = addr;
        sp_next_s = sp_r;
        data_s    = wdata;
        case (op)
            OP_LW, OP_SW: begin
                if ((ALIGN_CHK != 0) && ((addr & ALIGN_MASK) != {ADDR_W{1'b0}})) begin
                    fcode_s = FC_MIS;
                end else begin
                    start_s = 1'b1;
                end
            end
            OP_PUSH, OP_CALL: begin
                if (sp_x_s < LIM_X) begin
                    fcode_s = FC_OVF;
                end else begin
                    start_s   = 1'b1;
                    sp_next_s = sp_r - NB_SP;
                    base_s    = ADDR_W'(sp_r - NB_SP);
                end
                if (op == OP_CALL) begin
                    data_s = pc + PC_STEP;
                end else begin
                    data_s = wdata;
                end
            end
            OP_POP, OP_RET: begin
                if ((sp_x_s + NB_X) > BASE_X) begin
                    fcode_s = FC_UNF;
                end else begin
                    start_s   = 1'b1;
                    sp_next_s = sp_r + NB_SP;
                    base_s    = sp_r[ADDR_W-1:0];
                end
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Control FSM, stack pointer and registered responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            sp_r       <= SP_W'(STACK_BASE);
            op_r       <= 3'd0;
            addr_r     <= {ADDR_W{1'b0}};
            data_r     <= {DATA_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            rd_valid   <= 1'b0;
            rd_data    <= {DATA_W{1'b0}};
            ret_valid  <= 1'b0;
            ret_pc     <= {DATA_W{1'b0}};
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            rd_valid  <= 1'b0;
            ret_valid <= 1'b0;
            fault     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        fault_code <= fcode_s;
                        fault      <= (fcode_s != FC_NONE);
                        op_r       <= op;
                        addr_r     <= base_s;
                        data_r     <= data_s;
                        cnt_r      <= {CNT_W{1'b0}};
                        sp_r       <= sp_next_s;
                        state_r    <= start_s ? S_XFER : S_IDLE;
                    end
                end
                S_XFER: begin
                    addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    data_r <= shift_s;
                    cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= S_IDLE;
                        if ((op_r == OP_LW) || (op_r == OP_POP)) begin
                            rd_valid <= 1'b1;
                            rd_data  <= shift_s;
                        end else if (op_r == OP_RET) begin
                            ret_valid <= 1'b1;
                            ret_pc    <= shift_s;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Byte store; the array itself is never reset.
    always_ff @(posedge clk) begin
        if ((state_r == S_XFER) && wr_s) begin
            mem[addr_r] <= data_r[7:0];
        end
    end

endmodule

// File: tb/tb_data_stack_mem_seq.sv
// Scoreboard bench: the driver queues expected responses, a negedge monitor pops and compares.
module tb_data_stack_mem_seq;

    localparam int NB = 4;
    localparam logic [1:0] K_RD = 2'd1, K_RET = 2'd2, K_FLT = 2'd3;
    localparam logic [2:0] OP_LW = 3'd1, OP_SW = 3'd2, OP_PUSH = 3'd3, OP_POP = 3'd4,
                           OP_CALL = 3'd5, OP_RET = 3'd6;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [9:0]  addr = 10'd0;
    logic [31:0] wdata = 32'd0, pc = 32'd0;

    logic        ready_a, rdv_a, retv_a, flt_a;
    logic [31:0] rdd_a, retpc_a;
    logic [10:0] sp_a;
    logic [1:0]  fc_a;
    logic        ready_b, rdv_b, retv_b, flt_b;
    logic [31:0] rdd_b, retpc_b;
    logic [10:0] sp_b;
    logic [1:0]  fc_b;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    data_stack_mem_seq dut_a (
        .clk(clk), .rst_n(rst_n), .op_valid(valid_a), .op_ready(ready_a), .op(op),
        .addr(addr), .wdata(wdata), .pc(pc), .rd_valid(rdv_a), .rd_data(rdd_a),
        .ret_valid(retv_a), .ret_pc(retpc_a), .sp(sp_a), .fault(flt_a), .fault_code(fc_a)
    );

    data_stack_mem_seq #(.ALIGN_CHK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .op_valid(valid_b), .op_ready(ready_b), .op(op),
        .addr(addr), .wdata(wdata), .pc(pc), .rd_valid(rdv_b), .rd_data(rdd_b),
        .ret_valid(retv_b), .ret_pc(retpc_b), .sp(sp_b), .fault(flt_b), .fault_code(fc_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_resp(input string nm, input exp_t e, input logic [1:0] k,
                                input logic [31:0] v);
        total++;
        if (e.kind !== k || e.val !== v || e.cyc != cyc) begin
            bad++;
            $display("FAIL %s: got kind=%0d val=%0h cyc=%0d expected kind=%0d val=%0h cyc=%0d",
                     nm, k, v, cyc, e.kind, e.val, e.cyc);
        end
    endtask

    // Monitor: any response pulse must match the head of that DUT's queue, on the expected cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rdv_a || retv_a || flt_a) begin
                if (q_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL resp_a: unexpected response rd=%0b ret=%0b flt=%0b", rdv_a, retv_a, flt_a);
                end else begin
                    compare_resp("resp_a", q_a.pop_front(),
                                 rdv_a ? K_RD : (retv_a ? K_RET : K_FLT),
                                 rdv_a ? rdd_a : (retv_a ? retpc_a : {30'd0, fc_a}));
                end
            end
            if (rdv_b || retv_b || flt_b) begin
                if (q_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL resp_b: unexpected response rd=%0b ret=%0b flt=%0b", rdv_b, retv_b, flt_b);
                end else begin
                    compare_resp("resp_b", q_b.pop_front(),
                                 rdv_b ? K_RD : (retv_b ? K_RET : K_FLT),
                                 rdv_b ? rdd_b : (retv_b ? retpc_b : {30'd0, fc_b}));
                end
            end
        end
    end

    // Issue one request to DUT d; returns at the negedge after the accept edge.
    task automatic issue(input int d, input logic [2:0] o, input logic [9:0] a,
                         input logic [31:0] w, input logic [31:0] p,
                         input logic [1:0] k, input logic [31:0] v);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!((d == 0) ? ready_a : ready_b) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL ready_timeout: got op_ready=0 expected 1 within 50 cycles");
        end
        op = o; addr = a; wdata = w; pc = p;
        if (d == 0) valid_a = 1'b1; else valid_b = 1'b1;
        if (k != 2'd0) begin
            e.kind = k;
            e.val  = v;
            e.cyc  = cyc + ((k == K_FLT) ? 1 : NB + 1);
            if (d == 0) q_a.push_back(e); else q_b.push_back(e);
        end
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        op = 3'd0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sp", sp_a, 11'd1024);
        chk("rst_ready", ready_a, 1'b1);
        chk("rst_fault_code", fc_a, 2'b00);

        // SW then LW round trip, little-endian byte placement
        issue(0, OP_SW, 10'h010, 32'hDEADBEEF, 32'd0, 2'd0, 32'd0);
        issue(0, OP_LW, 10'h010, 32'd0, 32'd0, K_RD, 32'hDEADBEEF);
        repeat (5) @(negedge clk);
        chk("byte_0x10", dut_a.mem[16], 8'hEF);

        // Stack push/pop ordering
        issue(0, OP_PUSH, 10'd0, 32'h11223344, 32'd0, 2'd0, 32'd0);
        chk("sp_push1", sp_a, 11'd1020);
        issue(0, OP_PUSH, 10'd0, 32'h55667788, 32'd0, 2'd0, 32'd0);
        chk("sp_push2", sp_a, 11'd1016);
        issue(0, OP_POP, 10'd0, 32'd0, 32'd0, K_RD, 32'h55667788);
        issue(0, OP_POP, 10'd0, 32'd0, 32'd0, K_RD, 32'h11223344);
        chk("sp_popped", sp_a, 11'd1024);

        // CALL/RET
        issue(0, OP_CALL, 10'd0, 32'd0, 32'h40, 2'd0, 32'd0);
        chk("sp_call", sp_a, 11'd1020);
        issue(0, OP_RET, 10'd0, 32'd0, 32'd0, K_RET, 32'h41);
        chk("sp_ret", sp_a, 11'd1024);

        // Underflow, then fill to the limit and overflow
        issue(0, OP_POP, 10'd0, 32'd0, 32'd0, K_FLT, 32'd3);
        chk("sp_underflow", sp_a, 11'd1024);
        for (int i = 0; i < 64; i++) begin
            issue(0, OP_PUSH, 10'd0, 32'h1000 + i, 32'd0, 2'd0, 32'd0);
        end
        chk("sp_full", sp_a, 11'd768);
        issue(0, OP_PUSH, 10'd0, 32'hBAD, 32'd0, K_FLT, 32'd2);
        chk("sp_overflow", sp_a, 11'd768);
        issue(0, OP_POP, 10'd0, 32'd0, 32'd0, K_RD, 32'h103F);
        chk("sp_after_pop", sp_a, 11'd772);

        // Misaligned load
        issue(0, OP_LW, 10'h013, 32'd0, 32'd0, K_FLT, 32'd1);

        // Wrap-around store with alignment checking disabled
        issue(1, OP_SW, 10'h3FC, 32'd0, 32'd0, 2'd0, 32'd0);
        issue(1, OP_SW, 10'h000, 32'd0, 32'd0, 2'd0, 32'd0);
        issue(1, OP_SW, 10'h3FE, 32'hA1B2C3D4, 32'd0, 2'd0, 32'd0);
        issue(1, OP_LW, 10'h3FC, 32'd0, 32'd0, K_RD, 32'hC3D40000);
        issue(1, OP_LW, 10'h000, 32'd0, 32'd0, K_RD, 32'h0000A1B2);
        repeat (8) @(negedge clk);

        // Reset in the middle of a load aborts it with no response
        issue(0, OP_PUSH, 10'd0, 32'h77, 32'd0, 2'd0, 32'd0);
        issue(0, OP_LW, 10'h010, 32'd0, 32'd0, 2'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sp", sp_a, 11'd1024);
        chk("mid_rst_ready", ready_a, 1'b1);
        chk("mid_rst_rd_valid", rdv_a, 1'b0);
        chk("mid_rst_rd_data", rdd_a, 32'd0);
        chk("mid_rst_ret_pc", retpc_a, 32'd0);
        chk("mid_rst_fault", flt_a, 1'b0);
        chk("mid_rst_fault_code", fc_a, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
